// File: rtl/dm_split.sv
// Data memory for the MEM stage. It takes requests through a valid/ready port and returns a registered one-cycle response.
// Misaligned accesses are split into two word-array accesses. Range and type errors are flagged on rsp_err.
module dm_split #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned AW          = 7,
    parameter int unsigned MISALIGN_EN = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_type,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

    state_t        state_q, state_d;

    logic          wr_q, err_q, cross_q;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic [2:0]    type_q;
    logic [3:0]    mask_q;
    logic [31:0]   wdata_q, rd0_q, rd1_q;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          accept_c;
    logic [2:0]    size_c;
    logic [3:0]    lanes_c;
    logic          misal_c, oor_c, type_bad_c, err_c, cross_c;

    logic [63:0]   wide_c;
    logic [7:0]    be_c;
    logic [AW-1:0] widx_c;
    logic [3:0]    wbe_c;
    logic [31:0]   wdat_c, rword_c, asm_c, ext_c;
    logic          mem_we_c;

    assign accept_c = (state_q == S_IDLE) && req_valid;

    // Decode and classify the incoming request before it is accepted.
    always_comb begin
        size_c  = 3'd4;
        lanes_c = 4'hF;
        case (req_type[1:0])
            2'd0:    begin size_c = 3'd1; lanes_c = 4'h1; end
            2'd1:    begin size_c = 3'd2; lanes_c = 4'h3; end
            default: begin size_c = 3'd4; lanes_c = 4'hF; end
        endcase
        type_bad_c = (req_type == 3'b011) || (req_type[2:1] == 2'b11);
        misal_c    = ((req_type[1:0] == 2'd1) && req_addr[0])
                  || ((req_type[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
        oor_c      = ((({1'b0, req_addr} + 33'(size_c) - 33'd1) >> 2) >= 33'(DEPTH_WORDS))
                  || (|req_addr[31:AW+2]);
        err_c      = type_bad_c || (req_wr && req_type[2]) || oor_c
                  || ((MISALIGN_EN == 32'd0) && misal_c);
        cross_c    = (({1'b0, req_addr[1:0]} + size_c) > 3'd4);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_ACC0;
            S_ACC0:  state_d = (cross_q && !err_q) ? S_ACC1 : S_RESP;
            S_ACC1:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Responses are decoded only from registered state, so they never depend on req_*.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || wr_q) ? 32'd0 : ext_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            cross_q <= 1'b0;
            idx_q   <= '0;
            off_q   <= 2'd0;
            type_q  <= 3'd0;
            mask_q  <= 4'd0;
            wdata_q <= 32'd0;
            rd0_q   <= 32'd0;
            rd1_q   <= 32'd0;
        end else begin
            if (accept_c) begin
                wr_q    <= req_wr;
                err_q   <= err_c;
                cross_q <= cross_c;
                idx_q   <= req_addr[AW+1:2];
                off_q   <= req_addr[1:0];
                type_q  <= req_type;
                mask_q  <= lanes_c;
                wdata_q <= req_wdata;
            end
            if (state_q == S_ACC0) rd0_q <= rword_c;
            if (state_q == S_ACC1) rd1_q <= rword_c;
        end
    end

    // Lane placement spans two words: the low half goes to word w and the high half to word w+1.
    always_comb begin
        wide_c   = {32'd0, wdata_q} << {off_q, 3'b000};
        be_c     = {4'd0, mask_q} << off_q;
        widx_c   = (state_q == S_ACC1) ? (idx_q + AW'(1)) : idx_q;
        wbe_c    = (state_q == S_ACC1) ? be_c[7:4] : be_c[3:0];
        wdat_c   = (state_q == S_ACC1) ? wide_c[63:32] : wide_c[31:0];
        rword_c  = mem_q[widx_c];
        mem_we_c = rstn && wr_q && !err_q
                && ((state_q == S_ACC0) || (state_q == S_ACC1));
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int k = 0; k < 4; k++) begin
                if (wbe_c[k]) mem_q[widx_c][8*k +: 8] <= wdat_c[8*k +: 8];
            end
        end
    end

    always_comb begin
        asm_c = 32'({rd1_q, rd0_q} >> {off_q, 3'b000});
        case (type_q)
            3'b000:  ext_c = {{24{asm_c[7]}},  asm_c[7:0]};
            3'b001:  ext_c = {{16{asm_c[15]}}, asm_c[15:0]};
            3'b100:  ext_c = {24'd0, asm_c[7:0]};
            3'b101:  ext_c = {16'd0, asm_c[15:0]};
            default: ext_c = asm_c;
        endcase
    end

endmodule

// File: tb/tb_dm_split.sv
// Testbench for dm_split: one instance with misaligned splitting enabled, one with it disabled.
// Results are checked against a byte-array reference model.
module tb_dm_split;

    localparam int unsigned DA = 128, AWA = 7, DB = 16, AWB = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_wr, a_rv, a_err;
    logic [31:0] a_addr, a_wdata, a_rd;
    logic [2:0]  a_type;
    logic        b_valid, b_ready, b_wr, b_rv, b_err;
    logic [31:0] b_addr, b_wdata, b_rd;
    logic [2:0]  b_type;

    dm_split #(.DEPTH_WORDS(DA), .AW(AWA), .MISALIGN_EN(1)) u_a (
        .clk(clk), .rstn(rstn), .req_valid(a_valid), .req_ready(a_ready), .req_wr(a_wr),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_type(a_type),
        .rsp_valid(a_rv), .rsp_rdata(a_rd), .rsp_err(a_err));

    dm_split #(.DEPTH_WORDS(DB), .AW(AWB), .MISALIGN_EN(0)) u_b (
        .clk(clk), .rstn(rstn), .req_valid(b_valid), .req_ready(b_ready), .req_wr(b_wr),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_type(b_type),
        .rsp_valid(b_rv), .rsp_rdata(b_rd), .rsp_err(b_err));

    int checks = 0;
    int errors = 0;
    logic [7:0] mdl [2][512];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sz_of(input logic [2:0] ty);
        case (ty[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit exp_err(input bit sel, input logic wr, input logic [31:0] addr,
                                   input logic [2:0] ty);
        logic [63:0] last;
        int unsigned depth;
        last  = {32'd0, addr} + 64'(sz_of(ty)) - 64'd1;
        depth = sel ? DB : DA;
        if (ty == 3'd3 || ty == 3'd6 || ty == 3'd7) return 1'b1;
        if (wr && ty[2]) return 1'b1;
        if ((last / 4) >= 64'(depth)) return 1'b1;
        if (sel && ((sz_of(ty) == 2 && addr % 2 != 0) || (sz_of(ty) == 4 && addr % 4 != 0)))
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input bit sel, input logic [31:0] addr,
                                             input logic [2:0] ty);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < int'(sz_of(ty)); i++)
            v = v | (32'(mdl[sel][int'(addr) + i]) << (8 * i));
        case (ty)
            3'd0:    return (v[7]  ? (v | 32'hFFFF_FF00) : v);
            3'd1:    return (v[15] ? (v | 32'hFFFF_0000) : v);
            default: return v;
        endcase
    endfunction

    // One request/response transaction, checked against the model (latency, pulse, err, data).
    task automatic run_req(input bit sel, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] ty,
                           output logic [31:0] rd, output logic er);
        int lat;
        bit ee;
        int exp_lat;
        logic [31:0] ed;
        @(negedge clk);
        for (int g = 0; g < 10 && !(sel ? b_ready : a_ready); g++) @(negedge clk);
        chk($sformatf("ready@%h", addr), 32'(sel ? b_ready : a_ready), 32'd1);
        if (sel) begin b_valid = 1; b_wr = wr; b_addr = addr; b_wdata = wdata; b_type = ty; end
        else     begin a_valid = 1; a_wr = wr; a_addr = addr; a_wdata = wdata; a_type = ty; end
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        lat = 0; rd = 32'hDEAD_BEEF; er = 1'bx;
        for (int k = 1; k <= 6; k++) begin
            if (sel ? b_rv : a_rv) begin
                lat = k;
                rd  = sel ? b_rd : a_rd;
                er  = sel ? b_err : a_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk($sformatf("pulse@%h", addr), 32'(sel ? b_rv : a_rv), 32'd0);
        ee      = exp_err(sel, wr, addr, ty);
        exp_lat = (!ee && ((addr % 4) + sz_of(ty) > 4)) ? 3 : 2;
        ed      = (ee || wr) ? 32'd0 : exp_load(sel, addr, ty);
        chk($sformatf("lat@%h", addr), 32'(lat), 32'(exp_lat));
        chk($sformatf("err@%h", addr), 32'(er), 32'(ee));
        chk($sformatf("rdata@%h", addr), rd, ed);
        if (wr && !ee) begin
            for (int i = 0; i < int'(sz_of(ty)); i++)
                mdl[sel][int'(addr) + i] = wdata[8*i +: 8];
        end
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        for (int s = 0; s < 2; s++) for (int i = 0; i < 512; i++) mdl[s][i] = 8'd0;
        rstn = 0;
        a_valid = 0; a_wr = 0; a_addr = 0; a_wdata = 0; a_type = 0;
        b_valid = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_type = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_valid", 32'(a_rv), 32'd0);
        chk("rst_rdata", a_rd, 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        @(negedge clk) rstn = 1;

        // Preload zeros into every word that is read later.
        for (int w = 0; w < 16; w++) run_req(0, 1, 32'(4 * w), 32'd0, 3'd2, rd, er);
        run_req(0, 1, 32'(4 * (DA - 2)), 32'd0, 3'd2, rd, er);
        run_req(0, 1, 32'(4 * (DA - 1)), 32'd0, 3'd2, rd, er);
        for (int w = 0; w < 16; w++) run_req(1, 1, 32'(4 * w), 32'd0, 3'd2, rd, er);

        run_req(0, 1, 32'h0, 32'h1122_3344, 3'd2, rd, er);
        run_req(0, 0, 32'h0, 32'd0, 3'd2, rd, er);   chk("lw0", rd, 32'h1122_3344);
        run_req(0, 1, 32'h5, 32'h80, 3'd0, rd, er);
        run_req(0, 0, 32'h5, 32'd0, 3'd0, rd, er);   chk("lb5", rd, 32'hFFFF_FF80);
        run_req(0, 0, 32'h5, 32'd0, 3'd4, rd, er);   chk("lbu5", rd, 32'h0000_0080);
        run_req(0, 0, 32'h4, 32'd0, 3'd2, rd, er);   chk("lw4", rd, 32'h0000_8000);
        run_req(0, 1, 32'h3, 32'hAABB_CCDD, 3'd2, rd, er);
        run_req(0, 0, 32'h0, 32'd0, 3'd2, rd, er);   chk("word0", rd, 32'hDD22_3344);
        run_req(0, 0, 32'h4, 32'd0, 3'd2, rd, er);   chk("word1", rd, 32'h00AA_BBCC);
        run_req(0, 0, 32'h3, 32'd0, 3'd2, rd, er);   chk("lw3", rd, 32'hAABB_CCDD);
        run_req(0, 0, 32'h3, 32'd0, 3'd1, rd, er);   chk("lh3", rd, 32'hFFFF_CCDD);

        run_req(1, 1, 32'h1, 32'h1234, 3'd1, rd, er);
        chk("b_sh_err", 32'(er), 32'd1);           chk("b_sh_rd", rd, 32'd0);
        run_req(1, 0, 32'h0, 32'd0, 3'd2, rd, er);   chk("b_word0", rd, 32'd0);

        run_req(0, 0, 32'(DA * 4 - 2), 32'd0, 3'd2, rd, er); chk("top_err", 32'(er), 32'd1);
        run_req(0, 0, 32'h0, 32'd0, 3'd3, rd, er);   chk("t011_err", 32'(er), 32'd1);
        run_req(0, 1, 32'h0, 32'h5555_5555, 3'd5, rd, er); chk("sw101_err", 32'(er), 32'd1);
        run_req(0, 0, 32'h0, 32'd0, 3'd2, rd, er);   chk("word0_kept", rd, 32'hDD22_3344);

        // Reset while in ACC1 of a split store: the first half stays, the second half and the response are dropped.
        @(negedge clk);
        a_valid = 1; a_wr = 1; a_addr = 32'h7; a_wdata = 32'hAABB_CCDD; a_type = 3'd2;
        @(posedge clk); #1 a_valid = 0;
        @(posedge clk); #1;
        chk("acc1_norsp", 32'(a_rv), 32'd0);
        @(negedge clk) rstn = 0;
        @(posedge clk); #1;
        chk("abort_rv", 32'(a_rv), 32'd0);
        chk("abort_ready", 32'(a_ready), 32'd1);
        @(negedge clk) rstn = 1;
        repeat (3) begin @(posedge clk); #1 chk("abort_quiet", 32'(a_rv), 32'd0); end
        mdl[0][7] = 8'hDD;
        run_req(0, 0, 32'h4, 32'd0, 3'd2, rd, er);   chk("abort_w1", rd, 32'hDDAA_BBCC);
        run_req(0, 0, 32'h8, 32'd0, 3'd2, rd, er);   chk("abort_w2", rd, 32'd0);

        for (int n = 0; n < 250; n++) begin
            logic [31:0] ad;
            int unsigned r;
            r  = $urandom_range(0, 9);
            ad = (r < 8) ? 32'($urandom_range(0, 59))
               : (r < 9) ? 32'($urandom_range(DA * 4 - 8, DA * 4 + 3)) : 32'($urandom);
            run_req(0, 1'($urandom_range(0, 1)), ad, $urandom, 3'($urandom_range(0, 7)), rd, er);
        end
        for (int n = 0; n < 80; n++) begin
            run_req(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 70)), $urandom,
                    3'($urandom_range(0, 7)), rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_split.md
Name: dm_split

Overview:
- Parametrised data memory for the pipeline's MEM stage, successor to the single-cycle byte/half/word data memory.
- Adds a valid/ready request port, a registered response and configurable depth.
- Misaligned accesses are handled in hardware: a small FSM splits them into two word-array accesses.
- Range and type errors are flagged explicitly, never silently returned as X.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words in the array; power of two, ≥ 2.
- AW, 7, word-index width; must equal log2(DEPTH_WORDS).
- MISALIGN_EN, 1, 1 = split misaligned accesses; 0 = flag them as errors.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_type  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected, valid with rsp_valid.

Behaviour:
- Reset (rstn=0 at edge):
  - State goes to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array is NOT cleared.
- Handshake:
  - Request is accepted on an edge where req_valid && req_ready; all request fields are latched.
  - req_valid while busy is ignored; the requester must hold it.
  - No response backpressure: rsp_valid is high for exactly one cycle.
- Size:
  - Size = 1/2/4 bytes from req_type[1:0].
  - Lanes are little-endian; byte k of a word is bits [8k+7:8k].
- Error conditions (checked at accept):
  - req_type is 011, 110 or 111.
  - Store with 100 or 101.
  - Last byte address (addr+size-1) has word index ≥ DEPTH_WORDS, or addr[31:AW+2] ≠ 0.
  - Misaligned access (addr[0] set for H; addr[1:0] ≠ 0 for W) with MISALIGN_EN=0.
  - On error: no memory write occurs; path is IDLE→ACC0→RESP with rsp_err=1 and rsp_rdata=0.
- FSM states: IDLE, ACC0, ACC1, RESP.
  - IDLE→ACC0 on accept.
  - ACC0:
    - Access word w = addr[AW+1:2].
    - Store writes only lanes covered from offset addr[1:0], up to lane 3.
    - Load captures the word.
    - →ACC1 if the access crosses a word boundary (offset+size > 4), else →RESP.
  - ACC1:
    - Access word w+1, lanes 0..(offset+size-5).
    - Store writes the remaining upper bytes of wdata.
    - Load captures the second word.
    - →RESP.
  - RESP:
    - rsp_valid=1.
    - rsp_rdata = assembled bytes, sign-extended (000/001) or zero-extended (100/101/010).
    - →IDLE.
- Latency from accept edge T:
  - Non-crossing or error: rsp_valid during cycle T+2.
  - Crossing: rsp_valid during cycle T+3.
  - Throughput: one request per 3 (or 4) cycles.
- Hazards:
  - The RESP-cycle combinational path does not depend on req_*.
  - A load issued after a store sees the stored data; accesses are serialised.
- Reset mid-operation:
  - Reset in ACC1 aborts; the ACC0 half of a split store stays written and the ACC1 half is not written.
  - No response is issued.
- Wrap-around: a crossing access at word DEPTH_WORDS-1 is an out-of-range error; there is no wrap to word 0 and no partial write.
- $display of writes is permitted, but only under a simulation-only guard.

Test Plan:
- Preload zeros. SW 0x11223344 @0x0, then LW @0x0 → rsp_rdata=0x11223344, rsp_err=0, rsp_valid 2 cycles after each accept.
- SB 0x80 @0x5, then LB @0x5 → 0xFFFFFF80; LBU @0x5 → 0x00000080; LW @0x4 → 0x00008000.
- SW 0xAABBCCDD @0x3 (crossing) → word0=0xDD223344, word1=0x00AABBCC; rsp at T+3. Then LW @0x3 → 0xAABBCCDD; LH @0x3 → 0xFFFFCCDD.
- MISALIGN_EN=0: SH 0x1234 @0x1 → rsp_err=1, rsp_rdata=0; word0 unchanged.
- Error requests, each → rsp_err=1 and no write:
  - LW @ (DEPTH_WORDS*4-2) → crossing past top.
  - req_type=011.
  - SW with type 101.
- SW 0xAABBCCDD @0x7 with rstn low in ACC1 → word1 lane3 = 0xDD, word2 untouched, no rsp_valid, req_ready=1 after reset.
